pc_fetch_ctrl: RTL and testbench

- Program-counter and instruction-fetch controller for the single-cycle MIPS datapath.
- Sits directly upstream of the PC+4 Adder: pc_o drives Adder src1_i (src2_i tied to 4), and Adder sum_o returns as pc_plus4_i.
- Holds the architectural PC and issues one request at a time to instruction memory.
- Delivers each fetched instruction to decode, and selects the next PC from sequential, branch, jump or flush sources.

---
 rtl/pc_fetch_pkg.sv | 18 +
 rtl/next_pc_sel.sv | 43 ++++
 rtl/pc_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch controller.
package pc_fetch_pkg;

    typedef enum logic [1:0] {BOOT, FETCH, ISSUE} state_t;

    typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_JMP, SEL_FLUSH} sel_t;

    localparam int PC_STEP = 4;

    // Redirect priority: flush > jump > branch > sequential.
    function automatic sel_t pick_sel(input logic flush, input logic jump, input logic branch);
        if (flush)       return SEL_FLUSH;
        else if (jump)   return SEL_JMP;
        else if (branch) return SEL_BR;
        else             return SEL_SEQ;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux with alignment handling.
// Build option PC_ALIGN_CHECK_EN: misaligned targets redirect to TRAP_PC instead of being truncated.
module next_pc_sel
    import pc_fetch_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] TRAP_PC = 32'h0000_0080
) (
    input  logic             flush,
    input  logic             jump,
    input  logic             branch,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] flush_pc,
    output logic [WIDTH-1:0] next_pc,
    output logic             misalign
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(PC_STEP - 1);

    logic [WIDTH-1:0] raw_pc;

    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    always_comb begin
        raw_pc = pc_plus4;
        unique case (pick_sel(flush, jump, branch))
            SEL_FLUSH: raw_pc = flush_pc;
            SEL_JMP:   raw_pc = jump_target;
            SEL_BR:    raw_pc = branch_target;
            default:   raw_pc = pc_plus4;
        endcase

`ifdef PC_ALIGN_CHECK_EN
        misalign = |(raw_pc & ALIGN_MASK);
        next_pc  = misalign ? TRAP_PC : raw_pc;
`else
        misalign = 1'b0;
        next_pc  = raw_pc & ~ALIGN_MASK;
`endif
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and single-outstanding instruction-fetch FSM feeding decode.
// Build option PC_ALIGN_CHECK_EN enables the misaligned-target trap and misalign_o pulse.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pc_plus4_i,
    input  logic             branch_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] flush_pc_i,
    input  logic             stall_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_data_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             instr_valid_o,
    output logic [31:0]      instr_o,
    output logic [31:0]      retired_o,
    output logic             misalign_o
);

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] addr_q;
    logic             req_q;
    logic             valid_q;
    logic [31:0]      instr_q;
    logic [31:0]      retired_q;
    logic             squash_q;
    logic             misalign_q;

    logic [WIDTH-1:0] next_pc;
    logic             next_misalign;

    next_pc_sel #(
        .WIDTH  (WIDTH),
        .TRAP_PC(TRAP_PC)
    ) u_next_pc_sel (
        .flush        (flush_i),
        .jump         (jump_i),
        .branch       (branch_i),
        .pc_plus4     (pc_plus4_i),
        .branch_target(branch_target_i),
        .jump_target  (jump_target_i),
        .flush_pc     (flush_pc_i),
        .next_pc      (next_pc),
        .misalign     (next_misalign)
    );

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            retired_q  <= '0;
            squash_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            unique case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    if (flush_i) begin
                        pc_q       <= next_pc;
                        addr_q     <= next_pc;
                        misalign_q <= next_misalign;
                    end else begin
                        addr_q <= pc_q;
                    end
                end

                FETCH: begin
                    if (imem_ack_i) begin
                        if (squash_q || flush_i) begin
                            // Stale response: drop it and re-request at the (possibly new) PC.
                            squash_q <= 1'b0;
                            if (flush_i) begin
                                pc_q       <= next_pc;
                                addr_q     <= next_pc;
                                misalign_q <= next_misalign;
                            end else begin
                                addr_q <= pc_q;
                            end
                        end else begin
                            instr_q <= imem_data_i;
                            valid_q <= 1'b1;
                            req_q   <= 1'b0;
                            state_q <= ISSUE;
                        end
                    end else if (flush_i) begin
                        // The request stays on the bus with its original address until acked.
                        pc_q       <= next_pc;
                        squash_q   <= 1'b1;
                        misalign_q <= next_misalign;
                    end
                end

                ISSUE: begin
                    if (flush_i || !stall_i) begin
                        if (!flush_i) begin
                            retired_q <= retired_q + 32'd1;
                        end
                        pc_q       <= next_pc;
                        addr_q     <= next_pc;
                        misalign_q <= next_misalign;
                        valid_q    <= 1'b0;
                        req_q      <= 1'b1;
                        state_q    <= FETCH;
                    end
                end

                default: state_q <= BOOT;
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign retired_o     = retired_q;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a latency-programmable instruction memory model.
module tb_pc_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_plus4_i;
    logic        branch_i, jump_i, flush_i, stall_i;
    logic [31:0] branch_target_i, jump_target_i, flush_pc_i;
    logic        imem_req_o, imem_ack_i;
    logic [31:0] imem_addr_o, imem_data_i;
    logic [31:0] pc_o, instr_o, retired_o;
    logic        instr_valid_o, misalign_o;

    logic [3:0]  mem_lat;
    logic [3:0]  wait_cnt;

    int checks = 0;
    int errors = 0;

    pc_fetch_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pc_plus4_i     (pc_plus4_i),
        .branch_i       (branch_i),
        .branch_target_i(branch_target_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .flush_i        (flush_i),
        .flush_pc_i     (flush_pc_i),
        .stall_i        (stall_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_data_i    (imem_data_i),
        .pc_o           (pc_o),
        .instr_valid_o  (instr_valid_o),
        .instr_o        (instr_o),
        .retired_o      (retired_o),
        .misalign_o     (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    // PC+4 adder and memory: ack after mem_lat cycles of held request, data = addr | 0xA000.
    assign pc_plus4_i  = pc_o + 32'd4;
    assign imem_ack_i  = imem_req_o && (wait_cnt == mem_lat);
    assign imem_data_i = imem_addr_o | 32'h0000_A000;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                         wait_cnt <= '0;
        else if (!imem_req_o || imem_ack_i) wait_cnt <= '0;
        else                                wait_cnt <= wait_cnt + 4'd1;
    end

    task automatic test_reset();
        rst_i = 1'b0; mem_lat = 4'd0;
        branch_i = 0; jump_i = 0; flush_i = 0; stall_i = 0;
        branch_target_i = '0; jump_target_i = '0; flush_pc_i = '0;
        repeat (2) @(negedge clk_i);
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr_o, 32'h0); end
        checks++; if ({imem_req_o, instr_valid_o, misalign_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {imem_req_o, instr_valid_o, misalign_o}); end
        checks++; if ({instr_o, retired_o} !== 64'h0) begin errors++; $display("FAIL reset_instr_retired: got %h want 0", {instr_o, retired_o}); end
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++; if ({imem_req_o, imem_addr_o, instr_valid_o} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL boot_first_req: got req=%b addr=%h v=%b want req=1 addr=0 v=0", imem_req_o, imem_addr_o, instr_valid_o); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++; if ({instr_valid_o, instr_o, pc_o} !== {1'b1, 32'hA000 + 32'(4*i), 32'(4*i)}) begin errors++; $display("FAIL seq_issue%0d: got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h", i, instr_valid_o, instr_o, pc_o, 32'hA000 + 32'(4*i), 32'(4*i)); end
            @(negedge clk_i);
            checks++; if ({instr_valid_o, imem_req_o, imem_addr_o, pc_o} !== {2'b01, 32'(4*i+4), 32'(4*i+4)}) begin errors++; $display("FAIL seq_fetch%0d: got v=%b req=%b addr=%h pc=%h want v=0 req=1 addr=pc=%h", i, instr_valid_o, imem_req_o, imem_addr_o, pc_o, 32'(4*i+4)); end
        end
        checks++; if (retired_o !== 32'd4) begin errors++; $display("FAIL seq_retired: got %0d want 4", retired_o); end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            checks++; if ({instr_valid_o, instr_o, pc_o, retired_o} !== {1'b1, 32'hA010, 32'h10, 32'd4}) begin errors++; $display("FAIL stall_hold%0d: got v=%b instr=%h pc=%h ret=%0d want v=1 instr=a010 pc=10 ret=4", k, instr_valid_o, instr_o, pc_o, retired_o); end
        end
        stall_i = 1'b0;
        @(negedge clk_i);
        checks++; if ({instr_valid_o, imem_req_o, imem_addr_o, pc_o, retired_o} !== {2'b01, 32'h14, 32'h14, 32'd5}) begin errors++; $display("FAIL stall_release: got v=%b req=%b addr=%h pc=%h ret=%0d want v=0 req=1 addr=pc=14 ret=5", instr_valid_o, imem_req_o, imem_addr_o, pc_o, retired_o); end
    endtask

    task automatic test_redirect_priority();
        @(negedge clk_i);
        checks++; if (instr_o !== 32'hA014) begin errors++; $display("FAIL prio_instr14: got %h want a014", instr_o); end
        jump_i = 1; jump_target_i = 32'h200; branch_i = 1; branch_target_i = 32'h100;
        @(negedge clk_i);
        jump_i = 0; branch_i = 0;
        checks++; if ({pc_o, imem_addr_o, retired_o} !== {32'h200, 32'h200, 32'd6}) begin errors++; $display("FAIL jump_over_branch: got pc=%h addr=%h ret=%0d want 200 200 6", pc_o, imem_addr_o, retired_o); end
        @(negedge clk_i);
        checks++; if (instr_o !== 32'hA200) begin errors++; $display("FAIL jump_instr: got %h want a200", instr_o); end
        branch_i = 1; branch_target_i = 32'h100;
        @(negedge clk_i);
        branch_i = 0;
        checks++; if ({pc_o, retired_o} !== {32'h100, 32'd7}) begin errors++; $display("FAIL branch_taken: got pc=%h ret=%0d want 100 7", pc_o, retired_o); end
        @(negedge clk_i);
        flush_i = 1; flush_pc_i = 32'h300; stall_i = 1; jump_i = 1; jump_target_i = 32'h200;
        @(negedge clk_i);
        flush_i = 0; stall_i = 0; jump_i = 0;
        checks++; if ({pc_o, instr_valid_o, retired_o} !== {32'h300, 1'b0, 32'd7}) begin errors++; $display("FAIL flush_issue_over_stall: got pc=%h v=%b ret=%0d want 300 0 7", pc_o, instr_valid_o, retired_o); end
    endtask

    task automatic test_flush_during_fetch();
        int waited;
        @(negedge clk_i);
        checks++; if (instr_o !== 32'hA300) begin errors++; $display("FAIL flush_instr300: got %h want a300", instr_o); end
        mem_lat = 4'd3; flush_i = 1; flush_pc_i = 32'h8;
        @(negedge clk_i);
        flush_i = 0;
        checks++; if ({imem_req_o, imem_addr_o, pc_o} !== {1'b1, 32'h8, 32'h8}) begin errors++; $display("FAIL slow_req8: got req=%b addr=%h pc=%h want 1 8 8", imem_req_o, imem_addr_o, pc_o); end
        @(negedge clk_i);
        flush_i = 1; flush_pc_i = 32'h400;
        @(negedge clk_i);
        flush_i = 0;
        checks++; if ({imem_addr_o, pc_o, instr_valid_o} !== {32'h8, 32'h400, 1'b0}) begin errors++; $display("FAIL flush_addr_held: got addr=%h pc=%h v=%b want 8 400 0", imem_addr_o, pc_o, instr_valid_o); end
        @(negedge clk_i);
        checks++; if ({imem_addr_o, imem_ack_i, instr_valid_o} !== {32'h8, 1'b1, 1'b0}) begin errors++; $display("FAIL flush_ack_old: got addr=%h ack=%b v=%b want 8 1 0", imem_addr_o, imem_ack_i, instr_valid_o); end
        @(negedge clk_i);
        checks++; if ({imem_req_o, imem_addr_o, instr_valid_o} !== {1'b1, 32'h400, 1'b0}) begin errors++; $display("FAIL flush_dropped: got req=%b addr=%h v=%b want 1 400 0", imem_req_o, imem_addr_o, instr_valid_o); end
        waited = 0;
        while (!instr_valid_o && waited < 10) begin
            @(negedge clk_i);
            waited++;
        end
        checks++; if (waited !== 4) begin errors++; $display("FAIL slow_latency: got %0d cycles want 4", waited); end
        checks++; if ({instr_o, pc_o, retired_o} !== {32'hA400, 32'h400, 32'd7}) begin errors++; $display("FAIL flush_target_fetch: got instr=%h pc=%h ret=%0d want a400 400 7", instr_o, pc_o, retired_o); end
    endtask

    task automatic test_async_reset();
        @(negedge clk_i);
        checks++; if ({imem_req_o, imem_addr_o, retired_o} !== {1'b1, 32'h404, 32'd8}) begin errors++; $display("FAIL prereset_fetch: got req=%b addr=%h ret=%0d want 1 404 8", imem_req_o, imem_addr_o, retired_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if ({imem_req_o, instr_valid_o, misalign_o, pc_o, imem_addr_o, instr_o, retired_o} !== {3'b000, 128'h0}) begin errors++; $display("FAIL async_reset: got req=%b v=%b m=%b pc=%h addr=%h instr=%h ret=%h want all 0", imem_req_o, instr_valid_o, misalign_o, pc_o, imem_addr_o, instr_o, retired_o); end
        mem_lat = 4'd0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL reboot_req: got req=%b addr=%h want 1 0", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_alignment_and_wrap();
        logic [31:0] exp_br, exp_fl;
        logic        exp_mis;
`ifdef PC_ALIGN_CHECK_EN
        exp_br = 32'h80; exp_fl = 32'h80; exp_mis = 1'b1;
`else
        exp_br = 32'h100; exp_fl = 32'h200; exp_mis = 1'b0;
`endif
        @(negedge clk_i);
        branch_i = 1; branch_target_i = 32'h102;
        @(negedge clk_i);
        branch_i = 0;
        checks++; if ({pc_o, misalign_o, retired_o} !== {exp_br, exp_mis, 32'd1}) begin errors++; $display("FAIL misalign_branch: got pc=%h m=%b ret=%0d want %h %b 1", pc_o, misalign_o, retired_o, exp_br, exp_mis); end
        @(negedge clk_i);
        checks++; if ({misalign_o, instr_valid_o} !== 2'b01) begin errors++; $display("FAIL misalign_pulse_end: got m=%b v=%b want 0 1", misalign_o, instr_valid_o); end
        flush_i = 1; flush_pc_i = 32'hFFFF_FFFC;
        @(negedge clk_i);
        flush_i = 0;
        checks++; if ({pc_o, retired_o} !== {32'hFFFF_FFFC, 32'd1}) begin errors++; $display("FAIL flush_top: got pc=%h ret=%0d want fffffffc 1", pc_o, retired_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        checks++; if ({pc_o, retired_o} !== {32'h0, 32'd2}) begin errors++; $display("FAIL pc_wrap: got pc=%h ret=%0d want 0 2", pc_o, retired_o); end
        flush_i = 1; flush_pc_i = 32'h203;
        @(negedge clk_i);
        flush_i = 0;
        checks++; if ({instr_valid_o, imem_req_o, imem_addr_o, pc_o, misalign_o} !== {2'b01, exp_fl, exp_fl, exp_mis}) begin errors++; $display("FAIL flush_on_ack: got v=%b req=%b addr=%h pc=%h m=%b want 0 1 %h %h %b", instr_valid_o, imem_req_o, imem_addr_o, pc_o, misalign_o, exp_fl, exp_fl, exp_mis); end
        @(negedge clk_i);
        checks++; if ({instr_valid_o, instr_o} !== {1'b1, exp_fl | 32'hA000}) begin errors++; $display("FAIL flush_on_ack_fetch: got v=%b instr=%h want 1 %h", instr_valid_o, instr_o, exp_fl | 32'hA000); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_priority();
        test_flush_during_fetch();
        test_async_reset();
        test_alignment_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
